axi_slv_mem_responder: RTL

AXI_SLV_MEM_RESPONDER -- requirements
Module: axi_slv_mem_responder

---
 rtl/axi_slv_mem_responder.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slv_mem_responder.sv
// AXI slave backed by an on-chip word memory. Write and read FSMs are independent
// and flag SLVERR for range, burst-type, size, ID and burst-length violations.
module axi_slv_mem_responder #(
  parameter int                    AXI_ADDR_W = 32,
  parameter int                    AXI_ID_W   = 4,
  parameter int                    AXI_DATA_W = 32,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                    MEM_DEPTH  = 256
) (
  input  logic                    i_aclk,
  input  logic                    i_aresetn,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_ADDR_W-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [AXI_ID_W-1:0]     awid,
  input  logic [1:0]              awlock,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    wlast,
  input  logic [AXI_ID_W-1:0]     wid,
  input  logic [AXI_DATA_W-1:0]   wdata,
  input  logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [AXI_ID_W-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [AXI_ADDR_W-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [AXI_ID_W-1:0]     arid,
  input  logic [1:0]              arlock,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [AXI_ID_W-1:0]     rid,
  output logic [1:0]              rresp,
  output logic [AXI_DATA_W-1:0]   rdata,
  output logic                    rlast
);

  localparam int         IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int         NLANE       = AXI_DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

  logic unused_lock;
  assign unused_lock = ^{awlock, arlock};

  // Borrow bit of the 33-bit subtraction flags addresses below BASE_ADDR.
  function automatic logic addr_ok(input logic [AXI_ADDR_W-1:0] a);
    logic [AXI_ADDR_W:0]   diff;
    logic [AXI_ADDR_W-1:0] idx;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    idx  = diff[AXI_ADDR_W-1:0] >> 2;
    return !diff[AXI_ADDR_W] && (idx < AXI_ADDR_W'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] a,
                                                      input logic [3:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [AXI_ADDR_W-1:0] step;
    logic [AXI_ADDR_W-1:0] wmask;
    step  = AXI_ADDR_W'(1) << size;
    wmask = ((AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size) - AXI_ADDR_W'(1);
    case (burst)
      2'b01:   return a + step;
      2'b10:   return (a & ~wmask) | ((a + step) & wmask);
      default: return a;
    endcase
  endfunction

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  logic [AXI_ADDR_W-1:0] aw_addr_q;
  logic [3:0]            aw_len_q;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q;
  logic [AXI_ID_W-1:0]   aw_id_q;
  logic [3:0]            w_beat_q;
  logic                  w_over_q;
  logic                  w_err_q;
  logic                  w_beat_err, w_early, w_mem_we;

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) w_state <= W_IDLE;
    else            w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs)         w_state_next = W_DATA;
      W_DATA:  if (w_hs && wlast) w_state_next = W_RESP;
      W_RESP:  if (b_hs)          w_state_next = W_IDLE;
      default:                    w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
  end

  // Once the announced length is exhausted without wlast, later beats are poisoned.
  always_comb begin
    w_beat_err = (aw_burst_q == 2'b11) || (aw_size_q > 3'd2) || (wid != aw_id_q) ||
                 !addr_ok(aw_addr_q) || w_over_q;
    w_early    = wlast && !w_over_q && (w_beat_q != aw_len_q);
    w_mem_we   = w_hs && !w_beat_err;
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_id_q    <= '0;
      w_beat_q   <= '0;
      w_over_q   <= 1'b0;
      w_err_q    <= 1'b0;
      bid        <= '0;
      bresp      <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_addr_q  <= awaddr;
        aw_len_q   <= awlen;
        aw_size_q  <= awsize;
        aw_burst_q <= awburst;
        aw_id_q    <= awid;
        w_beat_q   <= '0;
        w_over_q   <= 1'b0;
        w_err_q    <= 1'b0;
      end
      if (w_hs) begin
        aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
        w_err_q   <= w_err_q || w_beat_err || w_early;
        if (!w_over_q) begin
          if ((w_beat_q == aw_len_q) && !wlast) w_over_q <= 1'b1;
          else                                  w_beat_q <= w_beat_q + 4'd1;
        end
        if (wlast) begin
          bid   <= aw_id_q;
          bresp <= (w_err_q || w_beat_err || w_early) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Memory has no reset so contents survive an aborted burst.
  always_ff @(posedge i_aclk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wstrb[i]) mem[addr_idx(aw_addr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic [AXI_ADDR_W-1:0] ar_addr_q;
  logic [3:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic [3:0]            r_beat_q;
  logic                  r_last_q;
  logic [AXI_ADDR_W-1:0] r_ld_addr;
  logic [3:0]            r_ld_beat;
  logic                  r_ld_err, r_ld_last, r_load;

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) r_state <= R_IDLE;
    else            r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)             r_state_next = R_DATA;
      R_DATA:  if (r_hs && r_last_q)  r_state_next = R_IDLE;
      default:                        r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = (r_state == R_DATA) && r_last_q;
  end

  // The beat register is reloaded on AR accept or on acceptance of a non-final beat.
  always_comb begin
    if (r_state == R_IDLE) begin
      r_ld_addr = araddr;
      r_ld_beat = 4'd0;
      r_ld_err  = (arburst == 2'b11) || (arsize > 3'd2) || !addr_ok(araddr);
      r_ld_last = (arlen == 4'd0);
    end else begin
      r_ld_addr = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
      r_ld_beat = r_beat_q + 4'd1;
      r_ld_err  = (ar_burst_q == 2'b11) || (ar_size_q > 3'd2) || !addr_ok(r_ld_addr);
      r_ld_last = (r_ld_beat == ar_len_q);
    end
    r_load = ar_hs || (r_hs && !r_last_q);
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      r_last_q   <= 1'b0;
      rid        <= '0;
      rresp      <= RESP_OKAY;
      rdata      <= '0;
    end else begin
      if (ar_hs) begin
        ar_len_q   <= arlen;
        ar_size_q  <= arsize;
        ar_burst_q <= arburst;
        rid        <= arid;
      end
      if (r_load) begin
        ar_addr_q <= r_ld_addr;
        r_beat_q  <= r_ld_beat;
        r_last_q  <= r_ld_last;
        rresp     <= r_ld_err ? RESP_SLVERR : RESP_OKAY;
        rdata     <= r_ld_err ? '0 : mem[addr_idx(r_ld_addr)];
      end
    end
  end

endmodule
